// File: rtl/kapisma_sync.sv
// Scores a three-player keypad guessing round: priority winner plus clamped net score.
// One-cycle registered latency, no handshake; async active-low reset clears outputs.

module kapisma_tahmin (
  input  logic [1:0] s_i,
  input  logic [1:0] d_i,
  input  logic [3:0] sayi_i,
  output logic [3:0] sayi_tahmin_o,
  output logic       tahmin_dogru_o
);

  logic [1:0] col;
  logic [1:0] row;
  logic [3:0] row4;

  // A step count of 3 wraps back to the first column/row.
  assign col  = (s_i == 2'd3) ? 2'd0 : s_i;
  assign row  = (d_i == 2'd3) ? 2'd0 : d_i;
  assign row4 = {2'b00, row};

  assign sayi_tahmin_o  = (row4 << 1) + row4 + {2'b00, col} + 4'd1;
  assign tahmin_dogru_o = (sayi_tahmin_o == sayi_i);

endmodule

module kapisma_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] sag_adimlar,
  input  logic [5:0] asagi_adimlar,
  input  logic [3:0] sayi,
  output logic [1:0] kazanan,
  output logic [4:0] toplam_puan
);

  logic [3:0] tahmin1, tahmin2, tahmin3;
  logic       dogru1, dogru2, dogru3;
  logic [4:0] pos, neg;
  logic [1:0] kazanan_d, kazanan_q;
  logic [4:0] puan_d, puan_q;

  kapisma_tahmin u_oyuncu1 (
    .s_i           (sag_adimlar[5:4]),
    .d_i           (asagi_adimlar[5:4]),
    .sayi_i        (sayi),
    .sayi_tahmin_o (tahmin1),
    .tahmin_dogru_o(dogru1)
  );

  kapisma_tahmin u_oyuncu2 (
    .s_i           (sag_adimlar[3:2]),
    .d_i           (asagi_adimlar[3:2]),
    .sayi_i        (sayi),
    .sayi_tahmin_o (tahmin2),
    .tahmin_dogru_o(dogru2)
  );

  kapisma_tahmin u_oyuncu3 (
    .s_i           (sag_adimlar[1:0]),
    .d_i           (asagi_adimlar[1:0]),
    .sayi_i        (sayi),
    .sayi_tahmin_o (tahmin3),
    .tahmin_dogru_o(dogru3)
  );

  always_comb begin
    kazanan_d = 2'd0;
    pos       = 5'd0;
    neg       = 5'd0;
    puan_d    = 5'd0;

    // Player 3 outranks player 2.
    if (dogru1)      kazanan_d = 2'd1;
    else if (dogru3) kazanan_d = 2'd3;
    else if (dogru2) kazanan_d = 2'd2;

    if (dogru1) pos = pos + {1'b0, tahmin1};
    else        neg = neg + {1'b0, tahmin1};
    if (dogru2) pos = pos + {1'b0, tahmin2};
    else        neg = neg + {1'b0, tahmin2};
    if (dogru3) pos = pos + {1'b0, tahmin3};
    else        neg = neg + {1'b0, tahmin3};

    if (pos > neg) puan_d = pos - neg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kazanan_q <= 2'd0;
      puan_q    <= 5'd0;
    end else begin
      kazanan_q <= kazanan_d;
      puan_q    <= puan_d;
    end
  end

  assign kazanan     = kazanan_q;
  assign toplam_puan = puan_q;

endmodule

// File: tb/tb_kapisma_sync.sv
// Bench for kapisma_sync: directed table, reset sequence, exhaustive sweep and random vectors.
module tb_kapisma_sync;

  logic       clk;
  logic       rst_n;
  logic [5:0] sag_adimlar;
  logic [5:0] asagi_adimlar;
  logic [3:0] sayi;
  logic [1:0] kazanan;
  logic [4:0] toplam_puan;

  int n_tests = 0;
  int n_fail  = 0;

  kapisma_sync dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sag_adimlar  (sag_adimlar),
    .asagi_adimlar(asagi_adimlar),
    .sayi         (sayi),
    .kazanan      (kazanan),
    .toplam_puan  (toplam_puan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] sag;
    logic [5:0] asagi;
    logic [3:0] n;
    int         exp_k;
    int         exp_p;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: look the guess up on the keypad, rank by priority list, sum with plain ints.
  function automatic void model(input logic [5:0] sag, input logic [5:0] asagi,
                                input logic [3:0] n, output int k, output int p);
    int grid [3][3];
    int order [3];
    int g [3];
    bit ok [3];
    int pos, neg;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        grid[r][c] = r * 3 + c + 1;
    for (int pl = 0; pl < 3; pl++) begin
      int s, d;
      s = (int'(sag)   >> (2 * (2 - pl))) & 3;
      d = (int'(asagi) >> (2 * (2 - pl))) & 3;
      g[pl]  = grid[d % 3][s % 3];
      ok[pl] = (g[pl] == int'(n));
    end
    order[0] = 0; order[1] = 2; order[2] = 1;
    k = 0;
    for (int i = 0; i < 3; i++)
      if (k == 0 && ok[order[i]]) k = order[i] + 1;
    pos = 0; neg = 0;
    for (int pl = 0; pl < 3; pl++)
      if (ok[pl]) pos += g[pl]; else neg += g[pl];
    p = (pos > neg) ? pos - neg : 0;
  endfunction

  task automatic apply(input logic [5:0] s, input logic [5:0] d, input logic [3:0] n);
    @(negedge clk);
    sag_adimlar   = s;
    asagi_adimlar = d;
    sayi          = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl [7];
    int mk, mp;

    tbl[0] = '{6'b00_01_10, 6'b00_00_00, 4'd2, 2, 0};
    tbl[1] = '{6'b00_01_10, 6'b00_00_00, 4'd3, 3, 0};
    tbl[2] = '{6'b00_00_00, 6'b00_00_00, 4'd1, 1, 3};
    tbl[3] = '{6'b10_10_10, 6'b10_10_10, 4'd9, 1, 27};
    tbl[4] = '{6'b11_01_00, 6'b00_01_00, 4'd5, 2, 3};
    tbl[5] = '{6'b11_01_00, 6'b00_01_00, 4'd0, 0, 0};
    tbl[6] = '{6'b10_10_10, 6'b10_10_10, 4'd15, 0, 0};

    sag_adimlar   = '0;
    asagi_adimlar = '0;
    sayi          = 4'd1;
    rst_n         = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_kazanan", int'(kazanan), 0);
    check("reset_puan", int'(toplam_puan), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].sag, tbl[i].asagi, tbl[i].n);
      check($sformatf("table%0d_kazanan", i), int'(kazanan), tbl[i].exp_k);
      check($sformatf("table%0d_puan", i), int'(toplam_puan), tbl[i].exp_p);
    end

    // Mid-operation reset between edges, held across an edge, then released.
    apply(6'b10_10_10, 6'b10_10_10, 4'd9);
    check("pre_reset_puan", int'(toplam_puan), 27);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_kazanan", int'(kazanan), 0);
    check("async_reset_puan", int'(toplam_puan), 0);
    @(posedge clk);
    #1;
    check("held_reset_kazanan", int'(kazanan), 0);
    check("held_reset_puan", int'(toplam_puan), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("released_before_edge_puan", int'(toplam_puan), 0);
    @(posedge clk);
    #1;
    check("after_release_kazanan", int'(kazanan), 1);
    check("after_release_puan", int'(toplam_puan), 27);

    for (int s = 0; s < 64; s++)
      for (int d = 0; d < 64; d++)
        for (int n = 1; n <= 9; n++) begin
          apply(6'(s), 6'(d), 4'(n));
          model(6'(s), 6'(d), 4'(n), mk, mp);
          check($sformatf("sweep_k s=%0d d=%0d n=%0d", s, d, n), int'(kazanan), mk);
          check($sformatf("sweep_p s=%0d d=%0d n=%0d", s, d, n), int'(toplam_puan), mp);
        end

    for (int i = 0; i < 2000; i++) begin
      logic [5:0] rs, rd;
      logic [3:0] rn;
      rs = 6'($urandom_range(0, 63));
      rd = 6'($urandom_range(0, 63));
      rn = 4'($urandom_range(0, 15));
      apply(rs, rd, rn);
      model(rs, rd, rn, mk, mp);
      check($sformatf("rand_k s=%0d d=%0d n=%0d", rs, rd, rn), int'(kazanan), mk);
      check($sformatf("rand_p s=%0d d=%0d n=%0d", rs, rd, rn), int'(toplam_puan), mp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
